// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Subtraction is a + ~b + 1, so the carry register is seeded with the mode bit.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             carry_nxt;
  logic             accept;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    res_d     = res_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    bit_s     = x_q[0] ^ y_q[0] ^ c_q;
    carry_nxt = (x_q[0] & y_q[0]) | (c_q & (x_q[0] ^ y_q[0]));
    res_shift = {bit_s, res_q[WIDTH-1:1]};
    // start is only honoured outside RUN; DONE may chain straight into RUN.
    accept    = start && (state_q != RUN);

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        res_d = res_shift;
        c_d   = carry_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = res_shift;
          cout_d  = carry_nxt;
          // c_q here is the carry into the MSB position.
          ovf_d   = c_q ^ carry_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = RUN;
      x_d     = a;
      y_d     = sub ? ~b : b;
      res_d   = '0;
      c_d     = sub;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=8: hand-computed results,
// latency, busy/done timing, ignored start, back-to-back and mid-run reset.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  int checks;
  int errors;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sub         (sub),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operation at a negedge; the following posedge accepts it.
  // n counts negedges after the accepting edge; done must appear at n = W+1.
  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_sub, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int n;
    int busy_cnt;
    int hold_err;
    logic [W-1:0] prev_sum;
    logic seen;
    @(negedge clk);
    prev_sum = sum;
    start = 1'b1; a = op_a; b = op_b; sub = op_sub;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; sub = 1'b0;
    busy_cnt = 0; hold_err = 0; seen = 1'b0; n = 1;
    while (n <= 20 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (sum !== prev_sum) hold_err++;
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_seen_done"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_hold_during_run"}, 64'(hold_err), 64'd0);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_sum_holds"}, 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;

    // directed vectors
    run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("add_plain", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op("sub_zero",  8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("add_neg",   8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0);

    // start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h22; b = 8'h33; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; first_done = 0;
    for (int n = 1; n <= 25; n++) begin
      if (n == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h11; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      @(negedge clk);
    end
    start = 1'b0; a = '0; b = '0; sub = 1'b0;
    check("ign_done_count", 64'(done_cnt), 64'd1);
    check("ign_latency", 64'(first_done), 64'(W + 1));
    check("ign_sum", 64'(sum), 64'h55);

    // back-to-back: start held high through the DONE cycle
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0;
    @(negedge clk);
    a = 8'h01; b = 8'h01;
    first_done = 0; second_done = 0; done_cnt = 0;
    for (int n = 1; n <= 25; n++) begin
      if (n == 10) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = n;
          check("b2b_sum1", 64'(sum), 64'h30);
        end else begin
          second_done = n;
          check("b2b_sum2", 64'(sum), 64'h02);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_done_count", 64'(done_cnt), 64'd2);
    check("b2b_first_at", 64'(first_done), 64'(W + 1));
    check("b2b_second_at", 64'(second_done), 64'(2 * (W + 1)));

    // reset four cycles into RUN
    @(negedge clk);
    start = 1'b1; a = 8'h44; b = 8'h11; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", 64'(busy), 64'd1);
    check("mid_sum_before", 64'(sum), 64'h02);
    rst = 1'b1;
    #1;
    check("mid_busy_async", 64'(busy), 64'd0);
    check("mid_sum_async", 64'(sum), 64'd0);
    check("mid_cout_async", 64'(cout), 64'd0);
    check("mid_ovf_async", 64'(ovf), 64'd0);
    check("mid_done_async", 64'(done), 64'd0);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_no_done", 64'(done_cnt), 64'd0);
    check("mid_state_idle", 64'(state_dbg), 64'd0);
    run_op("after_rst", 8'h44, 8'h11, 1'b1, 8'h33, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
